// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the banked data RAM.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int bank_bits(input int banks);
    return $clog2(banks);
  endfunction

  function automatic int row_bits(input int bank_depth);
    return $clog2(bank_depth);
  endfunction

endpackage

// File: rtl/ram_banked_if.sv
// Access bus of the banked RAM: request side from the datapath, result side back.
// Handshake: a request (en=1) is accepted on any rising edge where ready=1 and
// rst=0; its result appears on out with out_valid=1 for exactly the following
// cycle. There is no backpressure, so one request per cycle is sustained.
interface ram_banked_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
);
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              ready;

  modport master (
    output in, addr, en, load,
    input  out, out_valid, ready
  );

  modport slave (
    input  in, addr, en, load,
    output out, out_valid, ready
  );
endinterface

// File: rtl/ram_bank.sv
// One bank of the RAM: synchronous write port, combinational read of the same row.
module ram_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[row] <= din;
  end

  assign dout = mem[row];

endmodule

// File: rtl/ram_banked.sv
// Banked synchronous data RAM with a post-reset zeroing sweep, registered
// read/write-through output and a valid strobe.
module ram_banked
  import ram_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BANKS      = 8,
  parameter int BANK_DEPTH = 8,
  localparam int BW        = bank_bits(BANKS),
  localparam int RW        = row_bits(BANK_DEPTH),
  localparam int ADDR_W    = BW + RW
) (
  input  logic        clk,
  input  logic        rst,
  ram_banked_if.slave bus,
  output state_t      dbg_state
);

  state_t           state;
  logic [RW-1:0]    cnt;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             ready_q;

  logic [BW-1:0]    bank_sel;
  logic [RW-1:0]    row_sel;
  logic [RW-1:0]    bank_row;
  logic [WIDTH-1:0] bank_din;
  logic [BANKS-1:0] bank_we;
  logic [WIDTH-1:0] rd [BANKS];

  assign bank_sel = bus.addr[ADDR_W-1:RW];
  assign row_sel  = bus.addr[RW-1:0];

  // The sweep drives every bank with the same row and zero data; while rst is
  // held nothing is written so the array keeps its contents.
  always_comb begin
    bank_we  = '0;
    bank_row = (state == INIT) ? cnt : row_sel;
    bank_din = (state == INIT) ? '0 : bus.in;
    for (int b = 0; b < BANKS; b++) begin
      if (!rst) begin
        if (state == INIT)
          bank_we[b] = 1'b1;
        else if (bus.en && bus.load && bank_sel == BW'(b))
          bank_we[b] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram_bank #(
      .WIDTH (WIDTH),
      .DEPTH (BANK_DEPTH),
      .ROW_W (RW)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we[b]),
      .row  (bank_row),
      .din  (bank_din),
      .dout (rd[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      cnt         <= '0;
      ready_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          out_valid_q <= 1'b0;
          cnt         <= cnt + 1'b1;
          if (&cnt) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          out_valid_q <= bus.en;
          // A write commits at this edge, so a read next cycle sees it directly.
          if (bus.en) out_q <= bus.load ? bus.in : rd[bank_sel];
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ready     = ready_q;
  assign dbg_state     = state;

endmodule
